// File: rtl/alu_ctrl_decode_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_decode_pkg
// Description : Shared ALU operation codes, RV32I opcode constants, operand
//               select encodings and immediate-format helper for the
//               ALU control decoder and the ALU it drives.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_decode_pkg;

  // ALU operation codes, shared with the ALU control input
  localparam logic [4:0] ALU_ADD                  = 5'd0;
  localparam logic [4:0] ALU_SUB                  = 5'd1;
  localparam logic [4:0] ALU_AND                  = 5'd2;
  localparam logic [4:0] ALU_OR                   = 5'd3;
  localparam logic [4:0] ALU_XOR                  = 5'd4;
  localparam logic [4:0] ALU_LOGIC_LEFT_MOVE      = 5'd5;
  localparam logic [4:0] ALU_LOGIC_RIGHT_MOVE     = 5'd6;
  localparam logic [4:0] ALU_ARI_RIGHT_MOVE       = 5'd7;
  localparam logic [4:0] ALU_COMPARE_E_ZERO       = 5'd8;
  localparam logic [4:0] ALU_COMPARE_UNE_ZERO     = 5'd9;
  localparam logic [4:0] ALU_COMPARE_SMA_ZERO     = 5'd10;
  localparam logic [4:0] ALU_COMPARE_BIGE_ZERO    = 5'd11;
  localparam logic [4:0] ALU_COMPARE_UNS_SMA_ZERO = 5'd12;
  localparam logic [4:0] ALU_COMPARE_UNS_BIGE_ZERO = 5'd13;

  // RV32I major opcodes
  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;

  // funct7 values that distinguish the alternate ALU forms
  localparam logic [6:0] c_F7_BASE = 7'b0000000;
  localparam logic [6:0] c_F7_ALT  = 7'b0100000;

  // Operand A / B select encodings
  localparam logic [1:0] c_SRC_A_RS1  = 2'b00;
  localparam logic [1:0] c_SRC_A_PC   = 2'b01;
  localparam logic [1:0] c_SRC_A_ZERO = 2'b10;
  localparam logic [1:0] c_SRC_B_RS2  = 2'b00;
  localparam logic [1:0] c_SRC_B_IMM  = 2'b01;
  localparam logic [1:0] c_SRC_B_FOUR = 2'b10;

  // Immediate layouts; SHAMT is the zero-extended shift amount of OP-IMM shifts
  typedef enum logic [2:0] {
    IMM_NONE  = 3'd0,
    IMM_I     = 3'd1,
    IMM_S     = 3'd2,
    IMM_B     = 3'd3,
    IMM_U     = 3'd4,
    IMM_J     = 3'd5,
    IMM_SHAMT = 3'd6
  } imm_fmt_e;

  // Assemble the 32-bit sign-extended immediate for a given format
  function automatic logic [31:0] build_imm(input logic [31:0] ins, input imm_fmt_e fmt);
    logic [31:0] v;
    case (fmt)
      IMM_I:     v = {{20{ins[31]}}, ins[31:20]};
      IMM_S:     v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:     v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U:     v = {ins[31:12], 12'b0};
      IMM_J:     v = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      IMM_SHAMT: v = {27'b0, ins[24:20]};
      default:   v = 32'b0;
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_decode_comb.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_decode_comb
// Description : Pure combinational RV32I instruction to ALU-control bundle
//               decode. Illegal encodings collapse to ALU_ADD with every
//               other control cleared and illegal set.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_decode_comb
  import alu_ctrl_decode_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 5
) (
  input  logic [31:0]       instr,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [1:0]        src_a_sel,
  output logic [1:0]        src_b_sel,
  output logic [XLEN-1:0]   imm,
  output logic              is_branch,
  output logic              wb_zero,
  output logic              illegal
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_is_imm;
  logic       w_f7_base;
  logic       w_f7_alt;

  assign w_opcode  = instr[6:0];
  assign w_funct3  = instr[14:12];
  assign w_funct7  = instr[31:25];
  assign w_is_imm  = (w_opcode == c_OPC_OP_IMM);
  assign w_f7_base = (w_funct7 == c_F7_BASE);
  assign w_f7_alt  = (w_funct7 == c_F7_ALT);

  logic [4:0] w_ctrl;
  logic [1:0] w_a_sel;
  logic [1:0] w_b_sel;
  imm_fmt_e   w_fmt;
  logic       w_branch;
  logic       w_wb_zero;
  logic       w_ill;

  // Raw decode of opcode/funct3/funct7; legality is folded in afterwards
  always_comb begin
    w_ctrl    = ALU_ADD;
    w_a_sel   = c_SRC_A_RS1;
    w_b_sel   = c_SRC_B_RS2;
    w_fmt     = IMM_NONE;
    w_branch  = 1'b0;
    w_wb_zero = 1'b0;
    w_ill     = 1'b0;
    case (w_opcode)
      c_OPC_OP, c_OPC_OP_IMM: begin
        if (w_is_imm) begin
          w_b_sel = c_SRC_B_IMM;
          w_fmt   = IMM_I;
        end
        case (w_funct3)
          3'b000: begin
            // SUB only exists in register form; ADDI ignores funct7 (it is immediate)
            if (!w_is_imm && w_f7_alt) w_ctrl = ALU_SUB;
            else if (!w_is_imm && !w_f7_base) w_ill = 1'b1;
          end
          3'b001: begin
            w_ctrl = ALU_LOGIC_LEFT_MOVE;
            if (w_is_imm) w_fmt = IMM_SHAMT;
            if (!w_f7_base) w_ill = 1'b1;
          end
          3'b010: begin
            w_ctrl    = ALU_COMPARE_SMA_ZERO;
            w_wb_zero = 1'b1;
            if (!w_is_imm && !w_f7_base) w_ill = 1'b1;
          end
          3'b011: begin
            w_ctrl    = ALU_COMPARE_UNS_SMA_ZERO;
            w_wb_zero = 1'b1;
            if (!w_is_imm && !w_f7_base) w_ill = 1'b1;
          end
          3'b100: begin
            w_ctrl = ALU_XOR;
            if (!w_is_imm && !w_f7_base) w_ill = 1'b1;
          end
          3'b110: begin
            w_ctrl = ALU_OR;
            if (!w_is_imm && !w_f7_base) w_ill = 1'b1;
          end
          3'b111: begin
            w_ctrl = ALU_AND;
            if (!w_is_imm && !w_f7_base) w_ill = 1'b1;
          end
          default: begin
            // 3'b101: logical vs arithmetic right shift chosen by funct7
            if (w_is_imm) w_fmt = IMM_SHAMT;
            if (w_f7_base) w_ctrl = ALU_LOGIC_RIGHT_MOVE;
            else if (w_f7_alt) w_ctrl = ALU_ARI_RIGHT_MOVE;
            else w_ill = 1'b1;
          end
        endcase
      end
      c_OPC_BRANCH: begin
        w_branch = 1'b1;
        w_fmt    = IMM_B;
        case (w_funct3)
          3'b000:  w_ctrl = ALU_COMPARE_E_ZERO;
          3'b001:  w_ctrl = ALU_COMPARE_UNE_ZERO;
          3'b100:  w_ctrl = ALU_COMPARE_SMA_ZERO;
          3'b101:  w_ctrl = ALU_COMPARE_BIGE_ZERO;
          3'b110:  w_ctrl = ALU_COMPARE_UNS_SMA_ZERO;
          3'b111:  w_ctrl = ALU_COMPARE_UNS_BIGE_ZERO;
          default: w_ill  = 1'b1;
        endcase
      end
      c_OPC_LOAD: begin
        w_b_sel = c_SRC_B_IMM;
        w_fmt   = IMM_I;
      end
      c_OPC_STORE: begin
        w_b_sel = c_SRC_B_IMM;
        w_fmt   = IMM_S;
      end
      c_OPC_LUI: begin
        w_a_sel = c_SRC_A_ZERO;
        w_b_sel = c_SRC_B_IMM;
        w_fmt   = IMM_U;
      end
      c_OPC_AUIPC: begin
        w_a_sel = c_SRC_A_PC;
        w_b_sel = c_SRC_B_IMM;
        w_fmt   = IMM_U;
      end
      c_OPC_JAL: begin
        // ALU computes the link address pc+4; the jump offset rides on imm
        w_a_sel = c_SRC_A_PC;
        w_b_sel = c_SRC_B_FOUR;
        w_fmt   = IMM_J;
      end
      c_OPC_JALR: begin
        w_a_sel = c_SRC_A_PC;
        w_b_sel = c_SRC_B_FOUR;
        w_fmt   = IMM_I;
      end
      default: w_ill = 1'b1;
    endcase
  end

  // An illegal encoding presents a harmless ADD with every other control low
  assign alu_ctrl  = w_ill ? CTRL_W'(ALU_ADD) : CTRL_W'(w_ctrl);
  assign src_a_sel = w_ill ? 2'b00 : w_a_sel;
  assign src_b_sel = w_ill ? 2'b00 : w_b_sel;
  assign imm       = w_ill ? '0 : XLEN'($signed(build_imm(instr, w_fmt)));
  assign is_branch = w_branch & ~w_ill;
  assign wb_zero   = w_wb_zero & ~w_ill;
  assign illegal   = w_ill;

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_decode
// Description : Registered RV32I ALU-control decoder with valid/ready
//               handshake, a 2-entry (output + skid) buffer and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_decode
  import alu_ctrl_decode_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic [1:0]        src_a_sel,
  output logic [1:0]        src_b_sel,
  output logic [XLEN-1:0]   imm,
  output logic              is_branch,
  output logic              wb_zero,
  output logic              illegal
);

  // Decoded bundle of the incoming instruction
  logic [CTRL_W-1:0] w_dec_ctrl;
  logic [1:0]        w_dec_a_sel;
  logic [1:0]        w_dec_b_sel;
  logic [XLEN-1:0]   w_dec_imm;
  logic              w_dec_branch;
  logic              w_dec_wb_zero;
  logic              w_dec_illegal;

  alu_ctrl_decode_comb #(
    .XLEN   (XLEN),
    .CTRL_W (CTRL_W)
  ) u_decode (
    .instr     (instr),
    .alu_ctrl  (w_dec_ctrl),
    .src_a_sel (w_dec_a_sel),
    .src_b_sel (w_dec_b_sel),
    .imm       (w_dec_imm),
    .is_branch (w_dec_branch),
    .wb_zero   (w_dec_wb_zero),
    .illegal   (w_dec_illegal)
  );

  // Output register
  logic              r_out_valid;
  logic [CTRL_W-1:0] r_out_ctrl;
  logic [1:0]        r_out_a_sel;
  logic [1:0]        r_out_b_sel;
  logic [XLEN-1:0]   r_out_imm;
  logic              r_out_branch;
  logic              r_out_wb_zero;
  logic              r_out_illegal;

  // Skid entry
  logic              r_skid_valid;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [1:0]        r_skid_a_sel;
  logic [1:0]        r_skid_b_sel;
  logic [XLEN-1:0]   r_skid_imm;
  logic              r_skid_branch;
  logic              r_skid_wb_zero;
  logic              r_skid_illegal;

  logic w_accept;
  logic w_load_out;

  // in_ready comes straight from a flop, so it never depends on out_ready
  assign in_ready   = ~r_skid_valid;
  assign w_accept   = in_valid & ~r_skid_valid;
  // Output register can take a new bundle when empty or being consumed now
  assign w_load_out = ~r_out_valid | out_ready;

  // Output stage: skid entry has priority over a new instruction to keep order
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid   <= 1'b0;
      r_out_ctrl    <= '0;
      r_out_a_sel   <= '0;
      r_out_b_sel   <= '0;
      r_out_imm     <= '0;
      r_out_branch  <= 1'b0;
      r_out_wb_zero <= 1'b0;
      r_out_illegal <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_load_out) begin
      if (r_skid_valid) begin
        r_out_valid   <= 1'b1;
        r_out_ctrl    <= r_skid_ctrl;
        r_out_a_sel   <= r_skid_a_sel;
        r_out_b_sel   <= r_skid_b_sel;
        r_out_imm     <= r_skid_imm;
        r_out_branch  <= r_skid_branch;
        r_out_wb_zero <= r_skid_wb_zero;
        r_out_illegal <= r_skid_illegal;
      end else if (w_accept) begin
        r_out_valid   <= 1'b1;
        r_out_ctrl    <= w_dec_ctrl;
        r_out_a_sel   <= w_dec_a_sel;
        r_out_b_sel   <= w_dec_b_sel;
        r_out_imm     <= w_dec_imm;
        r_out_branch  <= w_dec_branch;
        r_out_wb_zero <= w_dec_wb_zero;
        r_out_illegal <= w_dec_illegal;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Skid stage: captures an accepted instruction while the output is stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_skid_valid   <= 1'b0;
      r_skid_ctrl    <= '0;
      r_skid_a_sel   <= '0;
      r_skid_b_sel   <= '0;
      r_skid_imm     <= '0;
      r_skid_branch  <= 1'b0;
      r_skid_wb_zero <= 1'b0;
      r_skid_illegal <= 1'b0;
    end else if (flush) begin
      r_skid_valid <= 1'b0;
    end else if (w_load_out) begin
      // Whatever was held here moves to the output this cycle
      r_skid_valid <= 1'b0;
    end else if (w_accept) begin
      r_skid_valid   <= 1'b1;
      r_skid_ctrl    <= w_dec_ctrl;
      r_skid_a_sel   <= w_dec_a_sel;
      r_skid_b_sel   <= w_dec_b_sel;
      r_skid_imm     <= w_dec_imm;
      r_skid_branch  <= w_dec_branch;
      r_skid_wb_zero <= w_dec_wb_zero;
      r_skid_illegal <= w_dec_illegal;
    end
  end

  assign out_valid = r_out_valid;
  assign alu_ctrl  = r_out_ctrl;
  assign src_a_sel = r_out_a_sel;
  assign src_b_sel = r_out_b_sel;
  assign imm       = r_out_imm;
  assign is_branch = r_out_branch;
  assign wb_zero   = r_out_wb_zero;
  assign illegal   = r_out_illegal;

endmodule
`default_nettype wire

// File: doc/alu_ctrl_decode.md
Name: alu_ctrl_decode

Overview:
- Execute-side producer of the ALU control interface.
- Accepts fetched RV32I instructions and decodes opcode/funct3/funct7 into the 5-bit ALU operation code, operand-select controls and sign-extended immediate.
- Registers the decoded bundle behind a valid/ready handshake with a 2-entry skid buffer.
- Sits between fetch and the ALU; its ALU code drives the ALU control input directly.

Parameters:
- XLEN, 32, datapath width of imm output.
- CTRL_W, 5, width of alu_ctrl; must match the ALU code width in define.v.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- flush  input  1  synchronous pipeline flush (branch redirect)
- in_valid  input  1  instr is valid
- in_ready  output  1  decoder can accept instr (registered, = !skid_valid)
- instr  input  32  raw RV32I instruction word
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  consumer accepts bundle
- alu_ctrl  output  CTRL_W  ALU operation code (define.v ALU_* value)
- src_a_sel  output  2  00 rs1, 01 pc, 10 zero
- src_b_sel  output  2  00 rs2, 01 imm, 10 constant 4
- imm  output  XLEN  sign-extended immediate (I/S/B/U/J per format; U pre-shifted <<12)
- is_branch  output  1  conditional branch; ALU zero output selects taken
- wb_zero  output  1  writeback takes zero-extended ALU zero flag (SLT family)
- illegal  output  1  unrecognised encoding; alu_ctrl = ALU_ADD, all other controls 0

Behaviour:
- Reset, with rst_n low at a rising edge:
  - out_valid=0, skid_valid=0, in_ready=1.
  - All bundle outputs 0.
  - in_valid is ignored while rst_n is low.
- Handshake:
  - Transfer on the input side when in_valid&in_ready.
  - Transfer on the output side when out_valid&out_ready.
  - Bundle outputs hold stable while out_valid&!out_ready.
- Latency: an accepted instr appears on outputs on the next rising edge if the output register is empty or draining the same cycle.
- Skid buffer:
  - If the output register is valid and not draining, an accepted instr decodes into the skid entry; in_ready drops the next cycle.
  - When the output drains, skid moves to output and in_ready returns to 1 the next cycle.
  - Order is preserved.
  - The buffer never holds more than 2 entries; throughput is 1/cycle with out_ready held high.
- Flush:
  - Flush at an edge clears out_valid and skid_valid.
  - Flush has priority over a same-cycle input acceptance, which is dropped.
  - in_ready=1 the next cycle.
  - Flush while rst_n is low behaves as reset.
- Decode table (macro names from define.v):
  - OP/OP-IMM ADD/ADDI: ALU_ADD. SUB (funct7=0100000): ALU_SUB.
  - AND/ANDI: ALU_AND. OR/ORI: ALU_OR. XOR/XORI: ALU_XOR.
  - SLL/SLLI: ALU_LOGIC_LEFT_MOVE. SRL/SRLI: ALU_LOGIC_RIGHT_MOVE. SRA/SRAI: ALU_ARI_RIGHT_MOVE.
  - SLT/SLTI: ALU_COMPARE_SMA_ZERO, wb_zero=1. SLTU/SLTIU: ALU_COMPARE_UNS_SMA_ZERO, wb_zero=1.
  - OP-IMM: src_b_sel=01. OP: src_b_sel=00.
  - BRANCH: BEQ ALU_COMPARE_E_ZERO, BNE ALU_COMPARE_UNE_ZERO, BLT ALU_COMPARE_SMA_ZERO, BGE ALU_COMPARE_BIGE_ZERO, BLTU ALU_COMPARE_UNS_SMA_ZERO, BGEU ALU_COMPARE_UNS_BIGE_ZERO. All branches: is_branch=1, B-imm.
  - LOAD/STORE: ALU_ADD, rs1+imm (I/S-imm).
  - LUI: ALU_ADD, src_a=zero, src_b=imm.
  - AUIPC: ALU_ADD, src_a=pc, src_b=imm.
  - JAL/JALR: ALU_ADD, src_a=pc, src_b=const4 (link); imm carries J/I offset.
- Illegal encodings:
  - Unknown opcode, funct3 010/011 on BRANCH, reserved funct7, shift-immediate with funct7 other than 0000000/0100000.
  - All of these set illegal=1 and still handshake normally.
- Registered outputs only; no combinational path from instr to any output.

Decomposition:
- ALU_* codes, opcode constants and src-select encodings live in define.v, shared with the ALU.
- One sub-module, alu_ctrl_decode_comb: pure combinational instr-to-bundle decode, instantiated once and feeding both the output and skid registers.

Test Plan:
- Reset then 0x002081B3 (ADD x3,x1,x2) with out_ready=1 -> next cycle out_valid=1, alu_ctrl=ALU_ADD, src_a_sel=00, src_b_sel=00, illegal=0.
- Back-to-back 0x402081B3, 0x4030D093 with out_ready=1 -> consecutive bundles:
  - ALU_SUB.
  - ALU_ARI_RIGHT_MOVE with imm=3, src_b_sel=01.
- 0x00208463 (BEQ +8) -> ALU_COMPARE_E_ZERO, is_branch=1, imm=0x00000008.
- 0x123452B7 (LUI) -> ALU_ADD, src_a_sel=10, imm=0x12345000. 0xFFFFFFFF -> illegal=1.
- out_ready=0, push 3 instrs:
  - Two accepted, in_ready=0 from the cycle after the second.
  - Raise out_ready: bundles drain in order; third accepted after in_ready returns.
- With skid full, assert flush together with in_valid -> next cycle out_valid=0, in_ready=1; the flushed-cycle instr never appears.
